// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and scancode lookup for the PS/2 to ZX key matrix bridge.
// Optional dual-key decode (Backspace, E0 arrows) under PS2_EXTKEYS_EN.
package ps2_keymatrix_pkg;

  localparam logic [7:0] ZX_E0 = 8'hE0;
  localparam logic [7:0] ZX_F0 = 8'hF0;
  localparam logic [7:0] ZX_AA = 8'hAA;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } zx_key_t;

  typedef struct packed {
    zx_key_t k0;
    zx_key_t k1;
  } zx_pair_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } rx_state_t;

  function automatic zx_key_t zk(input int r, input int c);
    zx_key_t k;
    k.valid = 1'b1;
    k.row   = 3'(r);
    k.col   = 3'(c);
    return k;
  endfunction

  // BAT completion and overrun codes wipe the matrix.
  function automatic logic is_clr_code(input logic [7:0] b);
    return (b == ZX_AA) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic zx_pair_t zx_lookup(input logic ext,
                                         input logic [7:0] code);
    zx_pair_t p;
    p = '0;
    if (!ext) begin
      case (code)
        8'h12: p.k0 = zk(0, 0);
        8'h1A: p.k0 = zk(0, 1);
        8'h22: p.k0 = zk(0, 2);
        8'h21: p.k0 = zk(0, 3);
        8'h2A: p.k0 = zk(0, 4);
        8'h1C: p.k0 = zk(1, 0);
        8'h1B: p.k0 = zk(1, 1);
        8'h23: p.k0 = zk(1, 2);
        8'h2B: p.k0 = zk(1, 3);
        8'h34: p.k0 = zk(1, 4);
        8'h15: p.k0 = zk(2, 0);
        8'h1D: p.k0 = zk(2, 1);
        8'h24: p.k0 = zk(2, 2);
        8'h2D: p.k0 = zk(2, 3);
        8'h2C: p.k0 = zk(2, 4);
        8'h16: p.k0 = zk(3, 0);
        8'h1E: p.k0 = zk(3, 1);
        8'h26: p.k0 = zk(3, 2);
        8'h25: p.k0 = zk(3, 3);
        8'h2E: p.k0 = zk(3, 4);
        8'h45: p.k0 = zk(4, 0);
        8'h46: p.k0 = zk(4, 1);
        8'h3E: p.k0 = zk(4, 2);
        8'h3D: p.k0 = zk(4, 3);
        8'h36: p.k0 = zk(4, 4);
        8'h4D: p.k0 = zk(5, 0);
        8'h44: p.k0 = zk(5, 1);
        8'h43: p.k0 = zk(5, 2);
        8'h3C: p.k0 = zk(5, 3);
        8'h35: p.k0 = zk(5, 4);
        8'h5A: p.k0 = zk(6, 0);
        8'h4B: p.k0 = zk(6, 1);
        8'h42: p.k0 = zk(6, 2);
        8'h3B: p.k0 = zk(6, 3);
        8'h33: p.k0 = zk(6, 4);
        8'h29: p.k0 = zk(7, 0);
        8'h59: p.k0 = zk(7, 1);
        8'h3A: p.k0 = zk(7, 2);
        8'h31: p.k0 = zk(7, 3);
        8'h32: p.k0 = zk(7, 4);
`ifdef PS2_EXTKEYS_EN
        8'h66: begin
          p.k0 = zk(0, 0);
          p.k1 = zk(4, 0);
        end
`endif
        default: ;
      endcase
    end
`ifdef PS2_EXTKEYS_EN
    else begin
      case (code)
        8'h6B: begin
          p.k0 = zk(0, 0);
          p.k1 = zk(3, 4);
        end
        8'h72: begin
          p.k0 = zk(0, 0);
          p.k1 = zk(4, 4);
        end
        8'h75: begin
          p.k0 = zk(0, 0);
          p.k1 = zk(4, 3);
        end
        8'h74: begin
          p.k0 = zk(0, 0);
          p.k1 = zk(4, 2);
        end
        default: ;
      endcase
    end
`endif
    return p;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, clock glitch filter, frame FSM, watchdog.
// Out: data_byte + byte_stb on a good frame, frame_err on a bad one.
module ps2_rx
  import ps2_keymatrix_pkg::*;
#(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT_W  = 17
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] data_byte,
  output logic       byte_stb,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic [1:0]           csync_q;
  logic [1:0]           dsync_q;
  logic [FCW-1:0]       fcnt_q;
  logic                 filt_q;
  logic                 fprev_q;
  rx_state_t            st_q;
  logic [2:0]           bcnt_q;
  logic [7:0]           sh_q;
  logic                 par_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 stb_q;
  logic                 err_q;
  logic                 strobe;
  logic                 dbit;

  assign strobe    = fprev_q & ~filt_q;
  assign dbit      = dsync_q[1];
  assign data_byte = sh_q;
  assign byte_stb  = stb_q;
  assign frame_err = err_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      fcnt_q  <= '0;
      filt_q  <= 1'b1;
      fprev_q <= 1'b1;
    end else begin
      csync_q <= {csync_q[0], ps2_clk_in};
      dsync_q <= {dsync_q[0], ps2_dat_in};
      fprev_q <= filt_q;
      if (csync_q[1] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q <= csync_q[1];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      bcnt_q <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      wd_q   <= '0;
      stb_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      err_q <= 1'b0;
      // Watchdog has priority over a coincident strobe.
      if (st_q != S_IDLE && wd_q == '1) begin
        st_q  <= S_IDLE;
        err_q <= 1'b1;
        wd_q  <= '0;
      end else begin
        if (st_q == S_IDLE || strobe) wd_q <= '0;
        else                          wd_q <= wd_q + 1'b1;
        if (strobe) begin
          unique case (st_q)
            S_IDLE: begin
              if (!dbit) begin
                st_q   <= S_DATA;
                bcnt_q <= '0;
              end
            end
            S_DATA: begin
              sh_q   <= {dbit, sh_q[7:1]};
              bcnt_q <= bcnt_q + 1'b1;
              if (bcnt_q == 3'd7) st_q <= S_PAR;
            end
            S_PAR: begin
              par_q <= dbit;
              st_q  <= S_STOP;
            end
            S_STOP: begin
              st_q <= S_IDLE;
              if (dbit && (^{sh_q, par_q})) stb_q <= 1'b1;
              else                          err_q <= 1'b1;
            end
            default: st_q <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard to 8x5 ZX Spectrum matrix, drives active-low kd.
// Ports: clk28, rst_n, ps2_clk_in/ps2_dat_in, a_hi (row select),
// kd, key_valid, frame_err. Macro PS2_EXTKEYS_EN enables dual keys.
module ps2_keymatrix
  import ps2_keymatrix_pkg::*;
#(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT_W  = 17
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic [7:0] a_hi,
  output logic [4:0] kd,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0]      rx_byte;
  logic            rx_stb;
  logic [7:0][4:0] mtx_q, mtx_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic            kv_q, kv_d;
  logic [4:0]      kd_q, kd_d;
  logic [4:0]      sel;
  zx_pair_t        pair;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_rx (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .data_byte (rx_byte),
    .byte_stb  (rx_stb),
    .frame_err (frame_err)
  );

  always_comb begin
    mtx_d = mtx_q;
    ext_d = ext_q;
    brk_d = brk_q;
    kv_d  = 1'b0;
    pair  = zx_lookup(ext_q, rx_byte);
    if (rx_stb) begin
      unique case (1'b1)
        (rx_byte == ZX_E0): ext_d = 1'b1;
        (rx_byte == ZX_F0): brk_d = 1'b1;
        is_clr_code(rx_byte): begin
          mtx_d = '0;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        default: begin
          if (pair.k0.valid) begin
            mtx_d[pair.k0.row][pair.k0.col] = ~brk_q;
            kv_d = 1'b1;
          end
          if (pair.k1.valid) begin
            mtx_d[pair.k1.row][pair.k1.col] = ~brk_q;
            kv_d = 1'b1;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel = '0;
    for (int r = 0; r < 8; r++) begin
      if (!a_hi[r]) sel = sel | mtx_q[r];
    end
    kd_d = ~sel;
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      mtx_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      kv_q  <= 1'b0;
      kd_q  <= 5'b11111;
    end else begin
      mtx_q <= mtx_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      kv_q  <= kv_d;
      kd_q  <= kd_d;
    end
  end

  assign kd        = kd_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: vector table, corner
// sequences and a randomized run against a key-matrix model.
module tb_ps2_keymatrix;

  logic       clk28;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] a_hi;
  logic [4:0] kd;
  logic       key_valid;
  logic       frame_err;

  int tests = 0;
  int fails = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;

  ps2_keymatrix #(
    .FILTER_LEN(4),
    .TIMEOUT_W (10)
  ) dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .ps2_clk_in(ps2_clk),
    .ps2_dat_in(ps2_dat),
    .a_hi      (a_hi),
    .kd        (kd),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  always @(posedge clk28) begin
    if (key_valid) kv_cnt++;
    if (frame_err) fe_cnt++;
  end

  // Spectrum matrix written as set-2 scancodes, row by row.
  int codes [8][5] = '{
    '{'h12, 'h1A, 'h22, 'h21, 'h2A},
    '{'h1C, 'h1B, 'h23, 'h2B, 'h34},
    '{'h15, 'h1D, 'h24, 'h2D, 'h2C},
    '{'h16, 'h1E, 'h26, 'h25, 'h2E},
    '{'h45, 'h46, 'h3E, 'h3D, 'h36},
    '{'h4D, 'h44, 'h43, 'h3C, 'h35},
    '{'h5A, 'h4B, 'h42, 'h3B, 'h33},
    '{'h29, 'h59, 'h3A, 'h31, 'h32}
  };

  int         pos0 [int];
  int         pos1 [int];
  int         pool [$];
  logic [4:0] m [8];

  typedef struct {
    logic [7:0] code;
    bit         brk;
    logic [7:0] a;
    logic [4:0] kd;
    int         kv;
  } vec_t;

  vec_t vt [$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk28);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_kd(input string nm, input logic [7:0] a,
                        input logic [4:0] e);
    a_hi = a;
    tick(3);
    @(negedge clk28);
    chk(nm, int'(kd), int'(e));
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    tick(8);
    ps2_clk = 1'b0;
    tick(16);
    ps2_clk = 1'b1;
    tick(8);
  endtask

  task automatic send_raw(input logic [7:0] b, input bit perr,
                          input bit serr);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ perr);
    ps2_bit(~serr);
    ps2_dat = 1'b1;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b0, 1'b0);
  endtask

  task automatic send_key(input int key, input bit brk);
    if (key >= 256) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(8'(key));
  endtask

  function automatic void add_dual(input int key, input int partner);
    pos0[key] = 0;
    pos1[key] = pos0[partner];
  endfunction

  function automatic void apply(input int key, input bit brk);
    int p;
    p = pos0[key];
    m[p / 5][p % 5] = ~brk;
    p = pos1[key];
    if (p >= 0) m[p / 5][p % 5] = ~brk;
  endfunction

  function automatic logic [4:0] exp_kd(input logic [7:0] a);
    logic [4:0] s;
    s = '0;
    for (int r = 0; r < 8; r++)
      if (!a[r]) s = s | m[r];
    return ~s;
  endfunction

  initial begin
    int kv0;
    int fe0;
    logic [7:0] ra;
    int key;
    bit brk;

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) begin
        pos0[codes[r][c]] = r * 5 + c;
        pos1[codes[r][c]] = -1;
      end
`ifdef PS2_EXTKEYS_EN
    add_dual('h066, 'h45);
    add_dual('h16B, 'h2E);
    add_dual('h172, 'h36);
    add_dual('h175, 'h3D);
    add_dual('h174, 'h3E);
`endif
    foreach (pos0[k]) pool.push_back(k);
    for (int r = 0; r < 8; r++) m[r] = '0;

    vt.push_back('{8'h1C, 1'b0, 8'hFD, 5'b11110, 1});
    vt.push_back('{8'h1C, 1'b1, 8'hFD, 5'b11111, 1});
    vt.push_back('{8'h1A, 1'b0, 8'hFE, 5'b11101, 1});
    vt.push_back('{8'h16, 1'b0, 8'hF6, 5'b11100, 1});
    vt.push_back('{8'h29, 1'b0, 8'h7F, 5'b11110, 1});
    vt.push_back('{8'h59, 1'b0, 8'h7F, 5'b11100, 1});
    vt.push_back('{8'h5A, 1'b0, 8'hBF, 5'b11110, 1});
    vt.push_back('{8'h12, 1'b0, 8'hFE, 5'b11100, 1});
    vt.push_back('{8'h1A, 1'b1, 8'hFE, 5'b11110, 1});
    vt.push_back('{8'h99, 1'b0, 8'h00, 5'b11100, 0});
`ifdef PS2_EXTKEYS_EN
    vt.push_back('{8'h66, 1'b0, 8'hEF, 5'b11110, 1});
    vt.push_back('{8'h66, 1'b1, 8'hFE, 5'b11111, 1});
`else
    vt.push_back('{8'h66, 1'b0, 8'hEF, 5'b11111, 0});
    vt.push_back('{8'h66, 1'b1, 8'hFE, 5'b11110, 0});
`endif

    rst_n   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    a_hi    = 8'h00;
    tick(5);
    @(negedge clk28);
    chk("rst_kd", int'(kd), 'h1F);
    chk("rst_kv", int'(key_valid), 0);
    chk("rst_fe", int'(frame_err), 0);
    rst_n = 1'b1;
    chk_kd("post_rst_kd", 8'h00, 5'b11111);

    foreach (vt[i]) begin
      kv0 = kv_cnt;
      if (vt[i].brk) send_byte(8'hF0);
      send_byte(vt[i].code);
      tick(4);
      chk_kd($sformatf("vec%0d_kd", i), vt[i].a, vt[i].kd);
      chk($sformatf("vec%0d_kv", i), kv_cnt - kv0, vt[i].kv);
    end

    kv0 = kv_cnt;
    send_byte(8'hAA);
    chk_kd("aa_00", 8'h00, 5'b11111);
    chk_kd("aa_fe", 8'hFE, 5'b11111);
    chk_kd("aa_7f", 8'h7F, 5'b11111);
    chk_kd("aa_f7", 8'hF7, 5'b11111);
    chk("aa_kv", kv_cnt - kv0, 0);

    kv0 = kv_cnt;
    send_key('h16B, 1'b0);
`ifdef PS2_EXTKEYS_EN
    chk("left_kv", kv_cnt - kv0, 1);
    chk_kd("left_fe", 8'hFE, 5'b11110);
    chk_kd("left_f7", 8'hF7, 5'b01111);
    chk_kd("left_ef", 8'hEF, 5'b11111);
`else
    chk("left_kv", kv_cnt - kv0, 0);
    chk_kd("left_fe", 8'hFE, 5'b11111);
    chk_kd("left_f7", 8'hF7, 5'b11111);
`endif
    send_key('h16B, 1'b1);
    chk_kd("left_brk", 8'h00, 5'b11111);

    kv0 = kv_cnt;
    fe0 = fe_cnt;
    send_raw(8'h1C, 1'b1, 1'b0);
    chk_kd("par_kd", 8'hFD, 5'b11111);
    chk("par_fe", fe_cnt - fe0, 1);
    chk("par_kv", kv_cnt - kv0, 0);

    fe0 = fe_cnt;
    send_raw(8'h1C, 1'b0, 1'b1);
    chk_kd("stop_kd", 8'hFD, 5'b11111);
    chk("stop_fe", fe_cnt - fe0, 1);

    fe0 = fe_cnt;
    kv0 = kv_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    tick(1100);
    @(negedge clk28);
    chk("wd_fe", fe_cnt - fe0, 1);
    send_byte(8'h1C);
    chk_kd("wd_next_kd", 8'hFD, 5'b11110);
    chk("wd_next_kv", kv_cnt - kv0, 1);

    send_byte(8'h16);
    chk_kd("mid_held", 8'hF5, 5'b11110);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    tick(5);
    rst_n = 1'b0;
    tick(4);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    @(negedge clk28);
    chk("mid_rst_kd", int'(kd), 'h1F);
    rst_n = 1'b1;
    chk_kd("mid_00", 8'h00, 5'b11111);
    chk_kd("mid_fd", 8'hFD, 5'b11111);
    chk_kd("mid_f7", 8'hF7, 5'b11111);
    tick(1100);
    @(negedge clk28);
    chk("mid_kv", int'(key_valid), 0);

    for (int it = 0; it < 30; it++) begin
      kv0 = kv_cnt;
      if ($urandom_range(9) == 0) begin
        send_byte(8'hAA);
        for (int r = 0; r < 8; r++) m[r] = '0;
        tick(4);
        @(negedge clk28);
        chk($sformatf("rnd%0d_kv", it), kv_cnt - kv0, 0);
      end else begin
        key = pool[$urandom_range(pool.size() - 1)];
        brk = 1'($urandom_range(1));
        send_key(key, brk);
        apply(key, brk);
        tick(4);
        @(negedge clk28);
        chk($sformatf("rnd%0d_kv", it), kv_cnt - kv0, 1);
      end
      ra = 8'($urandom_range(255));
      chk_kd($sformatf("rnd%0d_kd", it), ra, exp_kd(ra));
    end
    chk_kd("rnd_all", 8'h00, exp_kd(8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
